// File: rtl/hfg_stage_classifier.sv
// Haar cascade stage evaluator: accumulates per-feature votes into a saturating stage sum
// and decides pass/reject per stage. Optional stage counter port under HFG_STAGE_COUNT_EN.
module hfg_stage_classifier #(
    parameter int unsigned FEAT_W = 21,
    parameter int unsigned VAL_W  = 16,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned STG_W  = 5
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iStart,
    input  logic              iFeature_Valid,
    input  logic [FEAT_W-1:0] iFeature,
    input  logic [FEAT_W-1:0] iNode_Thresh,
    input  logic [VAL_W-1:0]  iLeft_Val,
    input  logic [VAL_W-1:0]  iRight_Val,
    input  logic              iLast_In_Stage,
    input  logic              iLast_Stage,
    input  logic [ACC_W-1:0]  iStage_Thresh,
    output logic              oReady,
    output logic              oStage_Done,
    output logic              oWindow_Done,
    output logic              oWindow_Face
`ifdef HFG_STAGE_COUNT_EN
    ,
    output logic [STG_W-1:0]  oStage_Count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                   state_q, state_n;
    logic signed [ACC_W-1:0]  acc_q, acc_n;
    logic signed [ACC_W-1:0]  thresh_q, thresh_n;
    logic                     last_stage_q, last_stage_n;
    logic                     ready_n, stage_done_n, window_done_n, face_n;
    logic signed [VAL_W-1:0]  vote;
    logic signed [ACC_W:0]    sum;
    logic signed [ACC_W-1:0]  acc_sat;
    logic                     accept;
    logic                     pass;

`ifdef HFG_STAGE_COUNT_EN
    logic [STG_W-1:0] count_q, count_n;
    assign oStage_Count = count_q;
`endif

    // Vote selection and saturating accumulate; the extra sum bit exposes overflow.
    always_comb begin
        vote = ($signed(iFeature) < $signed(iNode_Thresh)) ? $signed(iLeft_Val)
                                                           : $signed(iRight_Val);
        sum  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(vote);
        case (sum[ACC_W:ACC_W-1])
            2'b01:   acc_sat = ACC_MAX;
            2'b10:   acc_sat = ACC_MIN;
            default: acc_sat = sum[ACC_W-1:0];
        endcase
        accept = iFeature_Valid && oReady;
        pass   = (acc_q >= thresh_q);
    end

    // Next-state and next-output logic; iStart overrides everything, including DECIDE.
    always_comb begin
        state_n       = state_q;
        acc_n         = acc_q;
        thresh_n      = thresh_q;
        last_stage_n  = last_stage_q;
        stage_done_n  = 1'b0;
        window_done_n = 1'b0;
        face_n        = oWindow_Face;
`ifdef HFG_STAGE_COUNT_EN
        count_n       = count_q;
`endif
        if (iStart) begin
            state_n = ACCUM;
            acc_n   = '0;
            face_n  = 1'b0;
`ifdef HFG_STAGE_COUNT_EN
            count_n = '0;
`endif
        end else begin
            case (state_q)
                IDLE: state_n = IDLE;
                ACCUM: begin
                    if (accept) begin
                        acc_n = acc_sat;
                        if (iLast_In_Stage) begin
                            state_n      = DECIDE;
                            thresh_n     = $signed(iStage_Thresh);
                            last_stage_n = iLast_Stage;
                        end
                    end
                end
                DECIDE: begin
                    if (pass) begin
`ifdef HFG_STAGE_COUNT_EN
                        count_n = (count_q == '1) ? count_q : count_q + STG_W'(1);
`endif
                        if (last_stage_q) begin
                            window_done_n = 1'b1;
                            face_n        = 1'b1;
                            state_n       = IDLE;
                        end else begin
                            stage_done_n = 1'b1;
                            acc_n        = '0;
                            state_n      = ACCUM;
                        end
                    end else begin
                        window_done_n = 1'b1;
                        face_n        = 1'b0;
                        state_n       = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        ready_n = (state_n == ACCUM);
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            thresh_q     <= '0;
            last_stage_q <= 1'b0;
            oReady       <= 1'b0;
            oStage_Done  <= 1'b0;
            oWindow_Done <= 1'b0;
            oWindow_Face <= 1'b0;
`ifdef HFG_STAGE_COUNT_EN
            count_q      <= '0;
`endif
        end else begin
            state_q      <= state_n;
            acc_q        <= acc_n;
            thresh_q     <= thresh_n;
            last_stage_q <= last_stage_n;
            oReady       <= ready_n;
            oStage_Done  <= stage_done_n;
            oWindow_Done <= window_done_n;
            oWindow_Face <= face_n;
`ifdef HFG_STAGE_COUNT_EN
            count_q      <= count_n;
`endif
        end
    end

endmodule

// File: tb/tb_hfg_stage_classifier.sv
// Scoreboard bench for hfg_stage_classifier: expected stage/window decisions are queued
// when each closing feature is driven and compared when the pulse appears.
module tb_hfg_stage_classifier;

    localparam int unsigned FEAT_W = 21;
    localparam int unsigned VAL_W  = 16;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned STG_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              iStart;
    logic              iFeature_Valid;
    logic [FEAT_W-1:0] iFeature;
    logic [FEAT_W-1:0] iNode_Thresh;
    logic [VAL_W-1:0]  iLeft_Val;
    logic [VAL_W-1:0]  iRight_Val;
    logic              iLast_In_Stage;
    logic              iLast_Stage;
    logic [ACC_W-1:0]  iStage_Thresh;
    logic              oReady, oStage_Done, oWindow_Done, oWindow_Face;
`ifdef HFG_STAGE_COUNT_EN
    logic [STG_W-1:0]  oStage_Count;
`endif

    hfg_stage_classifier #(
        .FEAT_W(FEAT_W), .VAL_W(VAL_W), .ACC_W(ACC_W), .STG_W(STG_W)
    ) dut (
        .iClk          (clk),
        .iReset_n      (rst_n),
        .iStart        (iStart),
        .iFeature_Valid(iFeature_Valid),
        .iFeature      (iFeature),
        .iNode_Thresh  (iNode_Thresh),
        .iLeft_Val     (iLeft_Val),
        .iRight_Val    (iRight_Val),
        .iLast_In_Stage(iLast_In_Stage),
        .iLast_Stage   (iLast_Stage),
        .iStage_Thresh (iStage_Thresh),
        .oReady        (oReady),
        .oStage_Done   (oStage_Done),
        .oWindow_Done  (oWindow_Done),
        .oWindow_Face  (oWindow_Face)
`ifdef HFG_STAGE_COUNT_EN
        ,
        .oStage_Count  (oStage_Count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit stage_done;
        bit window_done;
        bit face;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   model_count = 0;

    function automatic exp_t mk(input bit sd, input bit wd, input bit face);
        exp_t e;
        e.stage_done  = sd;
        e.window_done = wd;
        e.face        = face;
        return e;
    endfunction

    task automatic idle_inputs();
        iStart         = 1'b0;
        iFeature_Valid = 1'b0;
        iFeature       = '0;
        iNode_Thresh   = '0;
        iLeft_Val      = '0;
        iRight_Val     = '0;
        iLast_In_Stage = 1'b0;
        iLast_Stage    = 1'b0;
        iStage_Thresh  = '0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        iStart = 1'b1;
        @(posedge clk);
        #1 iStart = 1'b0;
        model_count = 0;
    endtask

    // Waits (bounded) for oReady, then presents one feature for exactly one accept edge.
    task automatic send_raw(input logic signed [FEAT_W-1:0] f, input logic signed [FEAT_W-1:0] nt,
                            input logic signed [VAL_W-1:0] lv, input logic signed [VAL_W-1:0] rv,
                            input bit last_in, input bit last_stg, input logic signed [ACC_W-1:0] st);
        int n = 0;
        @(negedge clk);
        while (oReady !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (oReady !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout got=%b want=1", oReady);
        end
        iFeature       = f;
        iNode_Thresh   = nt;
        iLeft_Val      = lv;
        iRight_Val     = rv;
        iLast_In_Stage = last_in;
        iLast_Stage    = last_stg;
        iStage_Thresh  = st;
        iFeature_Valid = 1'b1;
        @(posedge clk);
        #1;
        iFeature_Valid = 1'b0;
        iLast_In_Stage = 1'b0;
    endtask

    // Random left/right/equal path whose selected vote is v and the other is a decoy.
    task automatic send_vote(input logic signed [VAL_W-1:0] v, input bit last_in,
                             input bit last_stg, input logic signed [ACC_W-1:0] st);
        int r;
        int base;
        logic signed [FEAT_W-1:0] f, nt;
        logic signed [VAL_W-1:0]  lv, rv, decoy;
        r     = int'($urandom_range(0, 2));
        base  = int'($urandom_range(0, 2000)) - 1000;
        nt    = FEAT_W'(base);
        decoy = v ^ 16'sh5a5a;
        if (r == 0) begin
            f = nt - 21'sd1; lv = v; rv = decoy;
        end else if (r == 1) begin
            f = nt; lv = decoy; rv = v;
        end else begin
            f = nt + 21'sd1; lv = decoy; rv = v;
        end
        send_raw(f, nt, lv, rv, last_in, last_stg, st);
    endtask

    task automatic check_decision(input string name);
        exp_t e;
        @(negedge clk);
        total++;
        if (oStage_Done !== 1'b0 || oWindow_Done !== 1'b0 || oReady !== 1'b0) begin
            bad++;
            $display("FAIL %s_decide_cycle got sd=%b wd=%b rdy=%b want 0 0 0",
                     name, oStage_Done, oWindow_Done, oReady);
        end
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_scoreboard_empty got=0 want=1 entries", name);
            return;
        end
        e = exp_q.pop_front();
        total++;
        if ({oStage_Done, oWindow_Done, oWindow_Face} !== {e.stage_done, e.window_done, e.face}) begin
            bad++;
            $display("FAIL %s_pulse got sd=%b wd=%b face=%b want sd=%b wd=%b face=%b", name,
                     oStage_Done, oWindow_Done, oWindow_Face, e.stage_done, e.window_done, e.face);
        end
        total++;
        if (oReady !== e.stage_done) begin
            bad++;
            $display("FAIL %s_ready got=%b want=%b", name, oReady, e.stage_done);
        end
        if ((e.stage_done || e.face) && model_count < 31) model_count++;
`ifdef HFG_STAGE_COUNT_EN
        total++;
        if (oStage_Count !== STG_W'(model_count)) begin
            bad++;
            $display("FAIL %s_count got=%0d want=%0d", name, oStage_Count, model_count);
        end
`endif
        @(negedge clk);
        total++;
        if (oStage_Done !== 1'b0 || oWindow_Done !== 1'b0 || oWindow_Face !== e.face) begin
            bad++;
            $display("FAIL %s_after got sd=%b wd=%b face=%b want 0 0 %b",
                     name, oStage_Done, oWindow_Done, oWindow_Face, e.face);
        end
    endtask

    task automatic close_stage(input logic signed [VAL_W-1:0] v, input bit last_stg,
                               input logic signed [ACC_W-1:0] st, input exp_t e, input string name);
        exp_q.push_back(e);
        send_vote(v, 1'b1, last_stg, st);
        check_decision(name);
    endtask

    task automatic check_quiet(input string name, input bit want_ready);
        total++;
        if (oStage_Done !== 1'b0 || oWindow_Done !== 1'b0 || oReady !== want_ready) begin
            bad++;
            $display("FAIL %s got sd=%b wd=%b rdy=%b want 0 0 %b",
                     name, oStage_Done, oWindow_Done, oReady, want_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({oReady, oStage_Done, oWindow_Done, oWindow_Face} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0000",
                     {oReady, oStage_Done, oWindow_Done, oWindow_Face});
        end
`ifdef HFG_STAGE_COUNT_EN
        total++;
        if (oStage_Count !== '0) begin
            bad++;
            $display("FAIL reset_count got=%0d want=0", oStage_Count);
        end
`endif
        rst_n = 1'b1;
        pulse_start();
        send_vote(16'sd250, 1'b0, 1'b0, '0);
        send_vote(16'sd250, 1'b0, 1'b0, '0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({oReady, oStage_Done, oWindow_Done, oWindow_Face} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid_accum got=%b want=0000",
                     {oReady, oStage_Done, oWindow_Done, oWindow_Face});
        end
        @(negedge clk);
        rst_n = 1'b1;
        iFeature_Valid = 1'b1;
        iLast_In_Stage = 1'b1;
        iLast_Stage    = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_quiet("reset_ignore_valid", 1'b0);
        end
        idle_inputs();
        pulse_start();
        close_stage(16'sd10, 1'b1, 24'sd11, mk(0, 1, 0), "reset_no_residual");
    endtask

    task automatic test_stage_pass();
        pulse_start();
        send_vote(16'sd100, 1'b0, 1'b0, '0);
        send_vote(-16'sd40, 1'b0, 1'b0, '0);
        close_stage(16'sd25, 1'b0, 24'sd80, mk(1, 0, 0), "stage_pass");
        close_stage(16'sd0, 1'b1, 24'sd1, mk(0, 1, 0), "acc_cleared");
    endtask

    task automatic test_stage_fail();
        pulse_start();
        send_vote(16'sd100, 1'b0, 1'b0, '0);
        send_vote(-16'sd40, 1'b0, 1'b0, '0);
        close_stage(16'sd25, 1'b0, 24'sd90, mk(0, 1, 0), "stage_fail");
        pulse_start();
        send_vote(16'sd100, 1'b0, 1'b0, '0);
        send_vote(-16'sd40, 1'b0, 1'b0, '0);
        close_stage(16'sd25, 1'b1, 24'sd85, mk(0, 1, 1), "thresh_equal");
        pulse_start();
        send_vote(16'sd100, 1'b0, 1'b0, '0);
        send_vote(-16'sd40, 1'b0, 1'b0, '0);
        close_stage(16'sd25, 1'b1, 24'sd86, mk(0, 1, 0), "thresh_plus_one");
    endtask

    task automatic test_back_to_back();
        pulse_start();
        send_vote(16'sd50, 1'b0, 1'b0, '0);
        close_stage(16'sd50, 1'b0, 24'sd100, mk(1, 0, 0), "two_stage_first");
        close_stage(16'sd7, 1'b1, -24'sd5, mk(0, 1, 1), "two_stage_last");
        repeat (3) begin
            @(negedge clk);
            total++;
            if (oWindow_Face !== 1'b1 || oReady !== 1'b0 || oWindow_Done !== 1'b0) begin
                bad++;
                $display("FAIL face_hold got face=%b rdy=%b wd=%b want 1 0 0",
                         oWindow_Face, oReady, oWindow_Done);
            end
        end
        pulse_start();
        @(negedge clk);
        total++;
        if (oWindow_Face !== 1'b0 || oReady !== 1'b1) begin
            bad++;
            $display("FAIL face_cleared_by_start got face=%b rdy=%b want 0 1", oWindow_Face, oReady);
        end
    endtask

    task automatic test_equal_and_saturation();
        pulse_start();
        exp_q.push_back(mk(0, 1, 1));
        send_raw(-21'sd7, -21'sd7, -16'sd100, 16'sd3, 1'b1, 1'b1, 24'sd3);
        check_decision("equal_takes_right");
        pulse_start();
        repeat (299) send_vote(16'sd32767, 1'b0, 1'b0, '0);
        close_stage(16'sd32767, 1'b1, 24'sd8388607, mk(0, 1, 1), "sat_pos_max");
        pulse_start();
        repeat (300) send_vote(16'sd32767, 1'b0, 1'b0, '0);
        close_stage(-16'sd1, 1'b1, 24'sd8388607, mk(0, 1, 0), "sat_pos_minus_one");
        pulse_start();
        repeat (299) send_vote(-16'sd32768, 1'b0, 1'b0, '0);
        close_stage(-16'sd32768, 1'b1, -24'sd8388608, mk(0, 1, 1), "sat_neg_min");
        pulse_start();
        repeat (300) send_vote(-16'sd32768, 1'b0, 1'b0, '0);
        close_stage(16'sd1, 1'b1, -24'sd8388606, mk(0, 1, 0), "sat_neg_plus_one");
    endtask

    task automatic test_start_abort();
        pulse_start();
        send_vote(16'sd500, 1'b0, 1'b0, '0);
        @(negedge clk);
        iStart         = 1'b1;
        iFeature_Valid = 1'b1;
        iFeature       = '0;
        iNode_Thresh   = 21'sd1;
        iLeft_Val      = 16'sd1000;
        iRight_Val     = 16'sd1000;
        iLast_In_Stage = 1'b1;
        iLast_Stage    = 1'b1;
        iStage_Thresh  = '0;
        @(posedge clk);
        #1 idle_inputs();
        model_count = 0;
        repeat (3) begin
            @(negedge clk);
            check_quiet("abort_feature_dropped", 1'b1);
        end
        close_stage(16'sd10, 1'b1, 24'sd11, mk(0, 1, 0), "abort_clean_acc");
        pulse_start();
        send_vote(16'sd6, 1'b1, 1'b1, '0);
        @(negedge clk);
        iStart = 1'b1;
        @(posedge clk);
        #1 iStart = 1'b0;
        model_count = 0;
        @(negedge clk);
        check_quiet("abort_in_decide", 1'b1);
        close_stage(16'sd4, 1'b1, 24'sd5, mk(0, 1, 0), "abort_decide_clean");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stage_pass();
        test_stage_fail();
        test_back_to_back();
        test_equal_and_saturation();
        test_start_abort();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
